// File: rtl/alu_operand_stage.sv
// ============================================================================
// Module   : alu_operand_stage
// Purpose  : Operand fetch for the 32-bit ALU: decode, 8x32 register file with
//            write-back bypass, RAW scoreboard and a registered valid/ready output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_operand_stage #(
    parameter int NREGS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       a,
    output logic [31:0]       b,
    output logic [2:0]        ctrl,
    output logic [2:0]        rd_out,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [31:0]       wb_data,
    output logic [NREGS-1:0]  pending
);

    // Instruction fields
    logic [2:0]  w_op;
    logic        w_imm_sel;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs1;
    logic [2:0]  w_rs2;
    logic [15:0] w_imm16;
    logic        w_unused_bits;

    assign w_op          = in_instr[31:29];
    assign w_imm_sel     = in_instr[28];
    assign w_rd          = in_instr[27:25];
    assign w_rs1         = in_instr[24:22];
    assign w_rs2         = in_instr[21:19];
    assign w_imm16       = in_instr[15:0];
    assign w_unused_bits = ^in_instr[18:16];

    logic [31:0]      r_regs [NREGS];
    logic [NREGS-1:0] r_pending;
    logic             r_out_valid;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [2:0]       r_ctrl;
    logic [2:0]       r_rd_out;

    logic             w_wb_write;
    logic             w_byp1;
    logic             w_byp2;
    logic [31:0]      w_rs1_val;
    logic [31:0]      w_rs2_val;
    logic [31:0]      w_b_val;
    logic             w_hazard;
    logic             w_accept;
    logic [NREGS-1:0] w_pending_nxt;

    assign w_wb_write = wb_en && (wb_addr != 3'd0);
    assign w_byp1     = wb_en && (wb_addr == w_rs1);
    assign w_byp2     = wb_en && (wb_addr == w_rs2);

    // r0 is hardwired zero; a same-cycle write-back overrides the stored value
    always_comb begin
        w_rs1_val = r_regs[w_rs1];
        if (w_rs1 == 3'd0) begin
            w_rs1_val = 32'd0;
        end else if (w_byp1) begin
            w_rs1_val = wb_data;
        end

        w_rs2_val = r_regs[w_rs2];
        if (w_rs2 == 3'd0) begin
            w_rs2_val = 32'd0;
        end else if (w_byp2) begin
            w_rs2_val = wb_data;
        end

        w_b_val = w_imm_sel ? {{16{w_imm16[15]}}, w_imm16} : w_rs2_val;
    end

    // pending[0] is never set, so r0 sources can never hazard
    assign w_hazard = (r_pending[w_rs1] && !w_byp1) ||
                      (!w_imm_sel && r_pending[w_rs2] && !w_byp2);

    assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;

    // Clear on write-back first so a same-cycle issue to that rd wins
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_wb_write) begin
            w_pending_nxt[wb_addr] = 1'b0;
        end
        if (w_accept && (w_rd != 3'd0)) begin
            w_pending_nxt[w_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_pending   <= '0;
            r_out_valid <= 1'b0;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_ctrl      <= 3'd0;
            r_rd_out    <= 3'd0;
        end else begin
            if (w_wb_write) begin
                r_regs[wb_addr] <= wb_data;
            end
            r_pending <= w_pending_nxt;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_a         <= w_rs1_val;
                r_b         <= w_b_val;
                r_ctrl      <= w_op;
                r_rd_out    <= w_rd;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign a         = r_a;
    assign b         = r_b;
    assign ctrl      = r_ctrl;
    assign rd_out    = r_rd_out;
    assign pending   = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
// ============================================================================
// Module   : tb_alu_operand_stage
// Purpose  : Self-checking bench for alu_operand_stage against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic [2:0]  rd_out;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [31:0] wb_data;
    logic [7:0]  pending;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.NREGS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .ctrl      (ctrl),
        .rd_out    (rd_out),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .pending   (pending)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural model state
    logic [31:0] m_regs [8];
    logic [7:0]  m_pend;
    logic        m_ov;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_ctrl;
    logic [2:0]  m_rd;

    function automatic logic [31:0] mk(input logic [2:0] op, input logic imm, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2, input logic [15:0] imm16);
        return {op, imm, rd, rs1, rs2, 3'b000, imm16};
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] r);
        if (r == 3'd0) return 32'd0;
        if (wb_en && wb_addr == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic logic src_waits(input logic [2:0] r);
        return (r != 3'd0) && m_pend[r] && !(wb_en && wb_addr == r);
    endfunction

    function automatic logic m_ready();
        logic haz;
        haz = src_waits(in_instr[24:22]) || (!in_instr[28] && src_waits(in_instr[21:19]));
        return (!m_ov || out_ready) && !haz;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
        m_pend = 8'd0;
        m_ov   = 1'b0;
        m_a    = 32'd0;
        m_b    = 32'd0;
        m_ctrl = 3'd0;
        m_rd   = 3'd0;
    endtask

    // Evaluated with the inputs that were present at the clock edge
    task automatic model_edge();
        logic        acc;
        logic [31:0] va;
        logic [31:0] vb;
        if (reset) begin
            model_reset();
        end else begin
            acc = in_valid && m_ready();
            va  = m_read(in_instr[24:22]);
            vb  = in_instr[28] ? {{16{in_instr[15]}}, in_instr[15:0]} : m_read(in_instr[21:19]);
            if (wb_en && wb_addr != 3'd0) begin
                m_regs[wb_addr] = wb_data;
                m_pend[wb_addr] = 1'b0;
            end
            if (acc && in_instr[27:25] != 3'd0) m_pend[in_instr[27:25]] = 1'b1;
            if (acc) begin
                m_ov   = 1'b1;
                m_a    = va;
                m_b    = vb;
                m_ctrl = in_instr[31:29];
                m_rd   = in_instr[27:25];
            end else if (out_ready) begin
                m_ov = 1'b0;
            end
        end
    endtask

    task automatic step(input logic rst, input logic iv, input logic [31:0] ins, input logic ordy,
                        input logic we, input logic [2:0] wa, input logic [31:0] wd);
        reset     = rst;
        in_valid  = iv;
        in_instr  = ins;
        out_ready = ordy;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        #1;
        if (!rst) check_val("in_ready", 32'(in_ready), 32'(m_ready()));
        @(posedge clk);
        model_edge();
        #1;
        check_val("out_valid", 32'(out_valid), 32'(m_ov));
        check_val("pending", 32'(pending), 32'(m_pend));
        check_val("a", a, m_a);
        check_val("b", b, m_b);
        check_val("ctrl", 32'(ctrl), 32'(m_ctrl));
        check_val("rd_out", 32'(rd_out), 32'(m_rd));
    endtask

    logic [31:0] snap_a;

    initial begin
        model_reset();
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 3'd0, 32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_pending", 32'(pending), 32'd0);

        // Write r3 then issue with a negative immediate
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 3'd3, 32'h0000_00AA);
        step(1'b0, 1'b1, mk(3'd0, 1'b1, 3'd0, 3'd3, 3'd0, 16'hFFFF), 1'b1, 1'b0, 3'd0, 32'd0);
        check_val("t1_valid", 32'(out_valid), 32'd1);
        check_val("t1_a", a, 32'h0000_00AA);
        check_val("t1_b", b, 32'hFFFF_FFFF);
        check_val("t1_ctrl", 32'(ctrl), 32'd0);

        // RAW stall on r2, released by the write-back bypass
        step(1'b0, 1'b1, mk(3'd1, 1'b0, 3'd2, 3'd0, 3'd0, 16'd0), 1'b1, 1'b0, 3'd0, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, mk(3'd2, 1'b0, 3'd5, 3'd2, 3'd0, 16'd0), 1'b1, 1'b0, 3'd0, 32'd0);
            check_val("t2_stall_ready", 32'(in_ready), 32'd0);
            check_val("t2_stall_pend", 32'(pending), 32'h04);
        end
        step(1'b0, 1'b1, mk(3'd2, 1'b0, 3'd5, 3'd2, 3'd0, 16'd0), 1'b1, 1'b1, 3'd2, 32'h1234);
        check_val("t2_a", a, 32'h1234);
        check_val("t2_ctrl", 32'(ctrl), 32'd2);
        check_val("t2_pend", 32'(pending), 32'h20);

        // Back-pressure: outputs hold, then consume and accept on the same edge
        snap_a = a;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, mk(3'd3, 1'b1, 3'd0, 3'd0, 3'd0, 16'h0001), 1'b0, 1'b0, 3'd0, 32'd0);
            check_val("t3_hold_a", a, snap_a);
            check_val("t3_hold_ctrl", 32'(ctrl), 32'd2);
            check_val("t3_hold_ready", 32'(in_ready), 32'd0);
        end
        step(1'b0, 1'b1, mk(3'd3, 1'b1, 3'd0, 3'd0, 3'd0, 16'h0001), 1'b1, 1'b0, 3'd0, 32'd0);
        check_val("t3_valid", 32'(out_valid), 32'd1);
        check_val("t3_ctrl", 32'(ctrl), 32'd3);
        check_val("t3_b", b, 32'd1);

        // r0 ignores writes and never stalls
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 3'd0, 32'hDEAD_BEEF);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, mk(3'd4, 1'b0, 3'd0, 3'd0, 3'd0, 16'd0), 1'b1, 1'b0, 3'd0, 32'd0);
            check_val("t4_a", a, 32'd0);
            check_val("t4_b", b, 32'd0);
            check_val("t4_valid", 32'(out_valid), 32'd1);
            check_val("t4_pend0", 32'(pending[0]), 32'd0);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 3'd5, 32'h55);

        // Full throughput
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, mk(3'(i), 1'b1, 3'd0, 3'd0, 3'd0, 16'(i)), 1'b1, 1'b0, 3'd0, 32'd0);
            check_val("t5_valid", 32'(out_valid), 32'd1);
            check_val("t5_ctrl", 32'(ctrl), 32'(i));
        end

        // Reset with an op in flight and every register pending
        for (int r = 1; r < 8; r++) begin
            step(1'b0, 1'b1, mk(3'd1, 1'b0, 3'(r), 3'd0, 3'd0, 16'd0), 1'b1, 1'b0, 3'd0, 32'd0);
        end
        check_val("t6_pend_full", 32'(pending), 32'hFE);
        step(1'b1, 1'b1, mk(3'd1, 1'b0, 3'd1, 3'd0, 3'd0, 16'd0), 1'b1, 1'b1, 3'd3, 32'hFFFF);
        check_val("t6_valid", 32'(out_valid), 32'd0);
        check_val("t6_pend", 32'(pending), 32'd0);
        for (int r = 1; r < 8; r++) begin
            step(1'b0, 1'b1, mk(3'd0, 1'b0, 3'd0, 3'(r), 3'(r), 16'd0), 1'b1, 1'b0, 3'd0, 32'd0);
            check_val("t6_reg_a", a, 32'd0);
            check_val("t6_reg_b", b, 32'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 3) != 0), $urandom,
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
